// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types and helpers for the tensor-core A-operand distribution network
package tc_pkg;

    typedef enum logic [1:0] {
        TC_DN_BCAST   = 2'd0,
        TC_DN_SKEW    = 2'd1,
        TC_DN_SCATTER = 2'd2,
        TC_DN_RSVD    = 2'd3
    } tc_dn_mode_e;

    function automatic int tc_lane_w(input int num_tile, input int dw_data);
        return num_tile * dw_data;
    endfunction

    // The reserved encoding behaves as broadcast so mode_q never holds it.
    function automatic tc_dn_mode_e tc_dn_decode(input logic [1:0] m);
        case (m)
            2'd1:    return TC_DN_SKEW;
            2'd2:    return TC_DN_SCATTER;
            default: return TC_DN_BCAST;
        endcase
    endfunction

endpackage

// File: rtl/tc_vec_fifo.sv
// rtl/tc_vec_fifo.sv - vector FIFO with gated push, pop strobe and combinational head read
module tc_vec_fifo #(
    parameter int W     = 256,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_data_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/tc_a_dn_param.sv
// rtl/tc_a_dn_param.sv - A-operand distribution network: FIFO-buffered vectors fanned out to PE lanes
module tc_a_dn_param
    import tc_pkg::*;
#(
    parameter int NUM_TILE = 16,
    parameter int DW_DATA  = 16,
    parameter int N_PE     = 4,
    parameter int STEP     = 4,
    parameter int DEPTH    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [1:0]                        mode,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_TILE*DW_DATA-1:0]       in_a,
    input  logic                              out_ready,
    output logic [N_PE-1:0]                   out_valid,
    output logic [N_PE*NUM_TILE*DW_DATA-1:0]  out_a,
    output logic                              busy
);

    localparam int LANE_W = tc_lane_w(NUM_TILE, DW_DATA);
    localparam int HC_W   = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int RR_W   = (N_PE > 1) ? $clog2(N_PE) : 1;

    logic [LANE_W-1:0] head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              issue;
    logic              pop;

    tc_dn_mode_e       mode_q, mode_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_PE-1:0]   valid_q, valid_d;
    logic [LANE_W-1:0] lane_q [N_PE];
    logic [LANE_W-1:0] lane_d [N_PE];

    assign in_ready = !fifo_full;
    assign busy     = !fifo_empty || (|valid_q) || (hold_cnt_q != '0);
    assign issue    = out_ready && !fifo_empty;
    assign pop      = issue && (hold_cnt_q == HC_W'(STEP - 1));

    tc_vec_fifo #(
        .W     (LANE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (in_valid && !fifo_full),
        .push_data_i (in_a),
        .pop_i       (pop),
        .head_data_o (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    always_comb begin
        mode_d     = mode_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        valid_d    = valid_q;
        lane_d     = lane_q;

        if (!busy) begin
            mode_d = tc_dn_decode(mode);
        end

        if (issue) begin
            hold_cnt_d = pop ? '0 : hold_cnt_q + 1'b1;
        end

        if (pop && (mode_q == TC_DN_SCATTER)) begin
            rr_ptr_d = (rr_ptr_q == RR_W'(N_PE - 1)) ? '0 : rr_ptr_q + 1'b1;
        end

        // Without out_ready nothing below moves, so the PE array sees a stable beat.
        if (out_ready) begin
            case (mode_q)
                TC_DN_SKEW: begin
                    valid_d[0] = issue;
                    if (issue) begin
                        lane_d[0] = head;
                    end
                    for (int p = 1; p < N_PE; p++) begin
                        lane_d[p]  = lane_q[p-1];
                        valid_d[p] = valid_q[p-1];
                    end
                end
                TC_DN_SCATTER: begin
                    valid_d = '0;
                    if (issue) begin
                        lane_d[rr_ptr_q]  = head;
                        valid_d[rr_ptr_q] = 1'b1;
                    end
                end
                default: begin
                    valid_d = issue ? '1 : '0;
                    if (issue) begin
                        for (int p = 0; p < N_PE; p++) begin
                            lane_d[p] = head;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q     <= TC_DN_BCAST;
            hold_cnt_q <= '0;
            rr_ptr_q   <= '0;
            valid_q    <= '0;
            for (int p = 0; p < N_PE; p++) begin
                lane_q[p] <= '0;
            end
        end else begin
            mode_q     <= mode_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            valid_q    <= valid_d;
            lane_q     <= lane_d;
        end
    end

    assign out_valid = valid_q;

    for (genvar g = 0; g < N_PE; g++) begin : g_lane
        assign out_a[g*LANE_W +: LANE_W] = lane_q[g];
    end

endmodule

// File: tb/tb_tc_a_dn_param.sv
// tb/tb_tc_a_dn_param.sv - directed bench for tc_a_dn_param (STEP=4 and STEP=1 instances)
module tb_tc_a_dn_param;

    localparam int LW = 256;
    localparam int NP = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     mode;
    logic           in_valid;
    logic [LW-1:0]  in_a;
    logic           out_ready;

    logic           in_ready,    in_ready_s1;
    logic [NP-1:0]  out_valid,   out_valid_s1;
    logic [NP*LW-1:0] out_a,     out_a_s1;
    logic           busy,        busy_s1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tc_a_dn_param u_dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_a     (out_a),
        .busy      (busy)
    );

    tc_a_dn_param #(.STEP(1)) u_dut_s1 (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s1),
        .in_a      (in_a),
        .out_ready (out_ready),
        .out_valid (out_valid_s1),
        .out_a     (out_a_s1),
        .busy      (busy_s1)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] vec(input int base);
        logic [LW-1:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(base + i);
        return v;
    endfunction

    function automatic logic [LW-1:0] lane(input logic [NP*LW-1:0] a, input int p);
        return a[p*LW +: LW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [NP-1:0] exp_v;
        int            b;
        int            beats;

        reset = 1'b0; mode = 2'd0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0;
        tick();
        tick();
        chk("rst_valid", LW'(out_valid), '0);
        chk("rst_lane0", lane(out_a, 0), '0);
        chk("rst_lane3", lane(out_a, 3), '0);
        chk("rst_busy",  LW'(busy), '0);
        reset = 1'b1;
        tick();
        chk("rst_in_ready", LW'(in_ready), LW'(1));

        // broadcast, STEP=4
        mode = 2'd0; in_valid = 1'b1; in_a = vec(0);
        tick();
        in_valid = 1'b0;
        chk("bc_valid_pre", LW'(out_valid), '0);
        chk("bc_busy_pre",  LW'(busy), LW'(1));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bc_valid", LW'(out_valid), LW'(4'b1111));
            for (int p = 0; p < NP; p++) chk("bc_lane", lane(out_a, p), vec(0));
        end
        tick();
        chk("bc_valid_end", LW'(out_valid), '0);
        chk("bc_busy_end",  LW'(busy), '0);
        chk("bc_hold_data", lane(out_a, 2), vec(0));

        // skew with two vectors; a mid-run mode change must be ignored
        mode = 2'd1; in_valid = 1'b1; in_a = vec(0);
        tick();
        in_a = vec(16);
        for (int e = 1; e <= 12; e++) begin
            tick();
            in_valid = 1'b0;
            if (e == 3) mode = 2'd0;
            exp_v = '0;
            for (int p = 0; p < NP; p++) begin
                b = e - 1 - p;
                if (b >= 0 && b <= 7) begin
                    exp_v[p] = 1'b1;
                    chk("sk_lane", lane(out_a, p), vec(b < 4 ? 0 : 16));
                end
            end
            chk("sk_valid", LW'(out_valid), LW'(exp_v));
        end
        chk("sk_busy_end", LW'(busy), '0);

        // scatter on the STEP=1 instance
        do_reset();
        mode = 2'd2;
        for (int e = 0; e <= 6; e++) begin
            in_a     = vec(16 * e);
            in_valid = (e < 5);
            tick();
            if (e >= 1) begin
                exp_v = (e <= 5) ? 4'(1 << ((e - 1) % 4)) : 4'b0000;
                chk("sc_valid", LW'(out_valid_s1), LW'(exp_v));
                chk("sc_in_ready", LW'(in_ready_s1), LW'(1));
                if (e <= 5) chk("sc_lane", lane(out_a_s1, (e - 1) % 4), vec(16 * (e - 1)));
            end
        end
        chk("sc_busy_end", LW'(busy_s1), '0);

        // backpressure: fill, stall, then drain with a two-cycle stall in the middle
        do_reset();
        mode = 2'd0; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_a     = vec(16 * k);
            tick();
        end
        chk("bp_in_ready_full", LW'(in_ready), '0);
        chk("bp_valid_stall",   LW'(out_valid), '0);
        chk("bp_busy",          LW'(busy), LW'(1));
        in_a = vec(64);
        tick();
        tick();
        chk("bp_in_ready_hold", LW'(in_ready), '0);
        chk("bp_valid_frozen",  LW'(out_valid), '0);
        in_valid = 1'b0;
        beats = 0;
        for (int c = 0; c < 18; c++) begin
            out_ready = !(c == 6 || c == 7);
            tick();
            if (out_ready) beats++;
            chk("bp_valid", LW'(out_valid), LW'(4'b1111));
            chk("bp_lane0", lane(out_a, 0), vec(16 * ((beats - 1) / 4)));
            chk("bp_lane3", lane(out_a, 3), vec(16 * ((beats - 1) / 4)));
            chk("bp_in_ready", LW'(in_ready), LW'(beats >= 4));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_valid_end", LW'(out_valid), '0);
        chk("bp_busy_end",  LW'(busy), '0);

        // reset asserted mid-stream discards everything
        mode = 2'd0; in_valid = 1'b1; in_a = vec(32);
        tick();
        in_a = vec(48);
        tick();
        in_valid = 1'b0;
        tick();
        chk("mr_valid_pre", LW'(out_valid), LW'(4'b1111));
        reset = 1'b0;
        #1;
        chk("mr_valid_async", LW'(out_valid), '0);
        chk("mr_lane1_async", lane(out_a, 1), '0);
        chk("mr_busy_async",  LW'(busy), '0);
        tick();
        reset = 1'b1;
        tick();
        chk("mr_in_ready", LW'(in_ready), LW'(1));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mr_no_stale", LW'(out_valid), '0);
        end
        chk("mr_lane0", lane(out_a, 0), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
